// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB SRAM peripheral.
//   trans_t  : AHB transfer type encoding
//   size_t   : AHB transfer size encoding (bytes = 2**size)
//   state_e  : data-phase state machine encoding
//   RESP_*   : one-bit response encoding
//   is_misaligned() : byte-address alignment check against a transfer size
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SIZE_8    = 3'd0,
    SIZE_16   = 3'd1,
    SIZE_32   = 3'd2,
    SIZE_64   = 3'd3,
    SIZE_128  = 3'd4,
    SIZE_256  = 3'd5,
    SIZE_512  = 3'd6,
    SIZE_1024 = 3'd7
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // True when any address bit below 2**sz bytes is set.
  function automatic logic is_misaligned(input logic [2:0] sz, input logic [6:0] lo);
    logic [6:0] mask;
    mask = (7'd1 << sz) - 7'd1;
    return |(lo & mask);
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM storage for the AHB peripheral.
// Synchronous write with per-byte enables, synchronous read into a
// resettable output register that holds its value when re is low.
// A read and write to the same word on the same edge returns the
// freshly written bytes, so a pipelined read sees the preceding write.
// Ports:
//   clk, nReset  : clock, async active-low reset (output register only)
//   we, waddr, wdata, wstrb : write port
//   re, raddr    : read request
//   rdata        : registered read data
module ahb_sram_array #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int IdxW      = 10
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   we,
  input  logic [IdxW-1:0]        waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth/8-1:0] wstrb,
  input  logic                   re,
  input  logic [IdxW-1:0]        raddr,
  output logic [DataWidth-1:0]   rdata
);

  localparam int Lanes = DataWidth / 8;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] wmerge;
  logic [DataWidth-1:0] rdata_d, rdata_q;

  always_comb begin
    wmerge = mem_q[waddr];
    for (int b = 0; b < Lanes; b++) begin
      if (wstrb[b]) wmerge[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = (we && (raddr == waddr)) ? wmerge : mem_q[raddr];
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < Lanes; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_prph.sv
// AHB subordinate wrapping a word-organised SRAM.
// Accepts NONSEQ/SEQ address phases when sel & ready, inserts WaitStates
// wait cycles on OKAY transfers, and gives a two-cycle ERROR response on
// oversize, misaligned or out-of-range transfers. Address phases are
// pipelined: a new one is taken in the completing cycle of the previous.
// Optional build macro: AHB_SRAM_SECURE_EN -- when defined, nonSec
// transfers to the upper half of storage are answered with ERROR.
// Ports:
//   clk, nReset                 : clock, async active-low reset
//   sel, addr, size, trans,
//   write, nonSec, burst,
//   mastLock, ready             : address phase / bus ready inputs
//   wData, wStrb                : write data phase inputs
//   rData, readyOut, resp       : data phase outputs
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no data phase in progress; readyOut=1, resp=OKAY
// WAIT    | OKAY transfer; counting wait cycles, completes at count
// ERR1    | first error cycle; readyOut=0, resp=ERROR
// ERR2    | second error cycle; readyOut=1, resp=ERROR
module ahb_sram_prph
  import ahb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 1024,
  parameter int WaitStates = 0
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   sel,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [2:0]             burst,
  input  logic                   mastLock,
  input  logic [2:0]             size,
  input  logic                   nonSec,
  input  logic [1:0]             trans,
  input  logic [DataWidth-1:0]   wData,
  input  logic [DataWidth/8-1:0] wStrb,
  input  logic                   write,
  input  logic                   ready,
  output logic [DataWidth-1:0]   rData,
  output logic                   readyOut,
  output logic                   resp
);

  localparam int LaneW = $clog2(DataWidth / 8);
  localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW  = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WaitStates);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic                 take;
  logic                 addr_err;
  logic                 done;
  logic [AddrWidth-1:0] word_idx;
  logic [IdxW-1:0]      idx_in;
  logic                 mem_we, mem_re;

  assign word_idx = addr >> LaneW;
  assign idx_in   = word_idx[IdxW-1:0];

  always_comb begin
    addr_err = 1'b0;
    if (size > 3'(LaneW))                      addr_err = 1'b1;
    if (is_misaligned(size, addr[6:0]))        addr_err = 1'b1;
    if (word_idx >= AddrWidth'(Depth))         addr_err = 1'b1;
`ifdef AHB_SRAM_SECURE_EN
    if (nonSec && (word_idx >= AddrWidth'(Depth / 2))) addr_err = 1'b1;
`endif
  end

  assign done = (state_q == ST_WAIT) && (cnt_q == CntMax);

  always_comb begin
    readyOut = 1'b1;
    resp     = RESP_OKAY;
    case (state_q)
      ST_WAIT: readyOut = done;
      ST_ERR1: begin
        readyOut = 1'b0;
        resp     = RESP_ERROR;
      end
      ST_ERR2: resp = RESP_ERROR;
      default: ;
    endcase
  end

  // trans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY. A phase is only
  // taken when this subordinate is itself ready (IDLE, last wait, ERR2).
  assign take = sel & ready & trans[1] & readyOut;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    case (state_q)
      ST_WAIT: begin
        if (done) state_d = ST_IDLE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      cnt_d   = '0;
      write_d = write;
      idx_d   = idx_in;
      state_d = addr_err ? ST_ERR1 : ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  // Reads are launched at the accept edge so data is registered in time
  // for a zero-wait completion; writes commit at the completing edge.
  assign mem_we = done & write_q;
  assign mem_re = take & ~addr_err & ~write;

  ahb_sram_array #(
    .DataWidth(DataWidth),
    .Depth    (Depth),
    .IdxW     (IdxW)
  ) u_array (
    .clk   (clk),
    .nReset(nReset),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wData),
    .wstrb (wStrb),
    .re    (mem_re),
    .raddr (idx_in),
    .rdata (rData)
  );

  logic unused_ok;
  assign unused_ok = ^{burst, mastLock, nonSec, trans[0]};

endmodule

// File: tb/tb_ahb_sram_prph.sv
// Bench for ahb_sram_prph: one instance with no wait states, one with two.
module tb_ahb_sram_prph;

  localparam int DEPTH = 1024;
`ifdef AHB_SRAM_SECURE_EN
  localparam bit SECURE = 1'b1;
`else
  localparam bit SECURE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nReset;
  logic [2:0]  burst    = 3'b001;
  logic        mastLock = 1'b0;
  logic        sel      [2];
  logic [31:0] addr     [2];
  logic [2:0]  size     [2];
  logic        nonSec   [2];
  logic [1:0]  trans    [2];
  logic [31:0] wData    [2];
  logic [3:0]  wStrb    [2];
  logic        write    [2];
  logic [31:0] rData    [2];
  logic        readyOut [2];
  logic        resp     [2];

  logic [31:0] mdl     [2][DEPTH];
  logic [31:0] last_rd [2];
  int n_checks = 0;
  int n_errors = 0;

  ahb_sram_prph #(.DataWidth(32), .AddrWidth(32), .Depth(DEPTH), .WaitStates(0)) dut0 (
    .clk(clk), .nReset(nReset), .sel(sel[0]), .addr(addr[0]), .burst(burst),
    .mastLock(mastLock), .size(size[0]), .nonSec(nonSec[0]), .trans(trans[0]),
    .wData(wData[0]), .wStrb(wStrb[0]), .write(write[0]), .ready(readyOut[0]),
    .rData(rData[0]), .readyOut(readyOut[0]), .resp(resp[0]));

  ahb_sram_prph #(.DataWidth(32), .AddrWidth(32), .Depth(DEPTH), .WaitStates(2)) dut1 (
    .clk(clk), .nReset(nReset), .sel(sel[1]), .addr(addr[1]), .burst(burst),
    .mastLock(mastLock), .size(size[1]), .nonSec(nonSec[1]), .trans(trans[1]),
    .wData(wData[1]), .wStrb(wStrb[1]), .write(write[1]), .ready(readyOut[1]),
    .rData(rData[1]), .readyOut(readyOut[1]), .resp(resp[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz, input logic ns);
    int unsigned w;
    bit e;
    w = a / 4;
    e = (sz > 3'd2) || ((a % (32'd1 << sz)) != 0) || (w >= DEPTH);
    e = e || (SECURE && ns && (w >= DEPTH / 2));
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle(input int d);
    sel[d] = 1'b0; addr[d] = '0; size[d] = 3'd2; nonSec[d] = 1'b0;
    trans[d] = 2'b00; write[d] = 1'b0; wData[d] = '0; wStrb[d] = '0;
  endtask

  task automatic addr_phase(input int d, input logic [31:0] a, input logic [2:0] sz,
                            input logic wr, input logic ns);
    sel[d] = 1'b1; addr[d] = a; size[d] = sz; write[d] = wr; nonSec[d] = ns;
    trans[d] = 2'b10;
  endtask

  // One isolated transfer; entered and left just after a rising edge.
  task automatic xfer(input int d, input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic ns, input logic [31:0] wd, input logic [3:0] st);
    int low, idx;
    logic r_first, r_last;
    logic [31:0] rd;
    bit err;
    err = exp_err(a, sz, ns);
    addr_phase(d, a, sz, wr, ns);
    @(posedge clk); #1;
    sel[d] = 1'b0; trans[d] = 2'b00; wData[d] = wd; wStrb[d] = st;
    @(negedge clk);
    r_first = resp[d];
    low = 0;
    while (readyOut[d] !== 1'b1 && low < 40) begin
      low++;
      @(negedge clk);
    end
    r_last = resp[d];
    rd = rData[d];
    check_eq($sformatf("d%0d_wait_cycles a=%h", d, a), 64'(low), err ? 64'd1 : 64'(ws(d)));
    check_eq($sformatf("d%0d_resp_first a=%h", d, a), 64'(r_first), 64'(err));
    check_eq($sformatf("d%0d_resp_last a=%h", d, a), 64'(r_last), 64'(err));
    if (!err && !wr) begin
      idx = int'(a / 4);
      check_eq($sformatf("d%0d_read_data a=%h", d, a), 64'(rd), 64'(mdl[d][idx]));
      last_rd[d] = mdl[d][idx];
    end else begin
      check_eq($sformatf("d%0d_rdata_hold a=%h", d, a), 64'(rd), 64'(last_rd[d]));
    end
    if (!err && wr) begin
      idx = int'(a / 4);
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk); #1;
    drive_idle(d);
  endtask

  // Write immediately followed by a read of the same word, no bubble.
  task automatic pipe_wr_rd(input logic [31:0] a, input logic [31:0] wd);
    int idx;
    idx = int'(a / 4);
    addr_phase(0, a, 3'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    wData[0] = wd; wStrb[0] = 4'hF;
    addr_phase(0, a, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("pipe_wr_ready", 64'(readyOut[0]), 64'd1);
    check_eq("pipe_wr_resp", 64'(resp[0]), 64'd0);
    mdl[0][idx] = wd;
    @(posedge clk); #1;
    drive_idle(0);
    @(negedge clk);
    check_eq("pipe_rd_ready", 64'(readyOut[0]), 64'd1);
    check_eq("pipe_rd_resp", 64'(resp[0]), 64'd0);
    check_eq("pipe_rd_data", 64'(rData[0]), 64'(wd));
    last_rd[0] = wd;
    @(posedge clk); #1;
  endtask

  task automatic pipe_rd2(input logic [31:0] a0, input logic [31:0] a1);
    addr_phase(0, a0, 3'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    addr_phase(0, a1, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("pipe_rd0_ready", 64'(readyOut[0]), 64'd1);
    check_eq("pipe_rd0_data", 64'(rData[0]), 64'(mdl[0][a0 / 4]));
    @(posedge clk); #1;
    drive_idle(0);
    @(negedge clk);
    check_eq("pipe_rd1_ready", 64'(readyOut[0]), 64'd1);
    check_eq("pipe_rd1_data", 64'(rData[0]), 64'(mdl[0][a1 / 4]));
    last_rd[0] = mdl[0][a1 / 4];
    @(posedge clk); #1;
  endtask

  // IDLE/BUSY with sel: one ready cycle, no access, even to a bad address.
  task automatic idle_busy(input int d, input logic [1:0] t);
    sel[d] = 1'b1; trans[d] = t; addr[d] = 32'h1002; size[d] = 3'd3;
    @(posedge clk); #1;
    drive_idle(d);
    @(negedge clk);
    check_eq($sformatf("d%0d_idlebusy_ready", d), 64'(readyOut[d]), 64'd1);
    check_eq($sformatf("d%0d_idlebusy_resp", d), 64'(resp[d]), 64'd0);
    check_eq($sformatf("d%0d_idlebusy_rdata", d), 64'(rData[d]), 64'(last_rd[d]));
    @(posedge clk); #1;
  endtask

  initial begin
    int k, w;
    logic [31:0] a;
    nReset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      last_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), 64'(readyOut[d]), 64'd1);
      check_eq($sformatf("d%0d_rst_resp", d), 64'(resp[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_rdata", d), 64'(rData[d]), 64'd0);
    end
    @(posedge clk); #1;
    nReset = 1'b1;

    // Preload words 0..15 and 512..519 so every later read is known.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 24; i++) begin
        w = (i < 16) ? i : 512 + (i - 16);
        xfer(d, 32'(w * 4), 3'd2, 1'b1, 1'b0, $urandom, 4'hF);
      end
    end

    pipe_wr_rd(32'h10, 32'hDEADBEEF);
    xfer(1, 32'h20, 3'd2, 1'b0, 1'b0, '0, '0);

    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'h8, 3'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF);
      xfer(d, 32'h8, 3'd2, 1'b1, 1'b0, 32'h11223344, 4'b0101);
      xfer(d, 32'h8, 3'd2, 1'b0, 1'b0, '0, '0);
      check_eq($sformatf("d%0d_partial", d), 64'(last_rd[d]), 64'h00000000FF22FF44);
      xfer(d, 32'h0, 3'd3, 1'b0, 1'b0, '0, '0);
      xfer(d, 32'h2, 3'd2, 1'b1, 1'b0, 32'h0BAD0BAD, 4'hF);
      xfer(d, 32'h1000, 3'd2, 1'b1, 1'b0, 32'h0BAD0BAD, 4'hF);
      xfer(d, 32'h0, 3'd2, 1'b0, 1'b0, '0, '0);
      xfer(d, 32'h800, 3'd2, 1'b0, 1'b1, '0, '0);
      xfer(d, 32'h800, 3'd2, 1'b0, 1'b0, '0, '0);
      idle_busy(d, 2'b01);
      idle_busy(d, 2'b00);
    end

    pipe_rd2(32'h0, 32'h4);
    xfer(0, 32'h3C, 3'd2, 1'b1, 1'b0, 32'h5A5A1234, 4'hF);

    // Reset while dut1 is waiting on a write: the write must be dropped.
    addr_phase(1, 32'h14, 3'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    sel[1] = 1'b0; trans[1] = 2'b00; wData[1] = 32'hA5A5A5A5; wStrb[1] = 4'hF;
    @(negedge clk);
    check_eq("rst_mid_waiting", 64'(readyOut[1]), 64'd0);
    nReset = 1'b0;
    #1;
    check_eq("rst_mid_ready", 64'(readyOut[1]), 64'd1);
    check_eq("rst_mid_resp", 64'(resp[1]), 64'd0);
    check_eq("rst_mid_rdata", 64'(rData[1]), 64'd0);
    @(posedge clk); #1;
    drive_idle(1);
    nReset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    xfer(1, 32'h14, 3'd2, 1'b0, 1'b0, '0, '0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        k = $urandom_range(0, 11);
        if (k == 0) begin
          a = 32'h1000 + 32'($urandom_range(0, 255));
        end else begin
          w = (k <= 8) ? $urandom_range(0, 15) : 512 + $urandom_range(0, 7);
          a = 32'(w * 4);
          if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        end
        xfer(d, a, ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             4'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
